// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: operand width default,
// one-hot operation encodings, FSM state type and the digit-key decoder.
package calc_pkg;

  localparam int unsigned OPW_DEFAULT = 4;

  localparam logic [3:0] MODE_ADD = 4'b0001;
  localparam logic [3:0] MODE_MUL = 4'b0010;
  localparam logic [3:0] MODE_SUB = 4'b0100;
  localparam logic [3:0] MODE_DIV = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  // Returns {valid, digit}: bit i of n means digit i+1, all-zero means 0,
  // more than one key pressed is invalid.
  function automatic logic [4:0] decode_num(input logic [8:0] n);
    logic [3:0]  dig;
    int unsigned ones;
    dig  = '0;
    ones = 0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (n[i]) begin
        ones++;
        dig = 4'(i + 1);
      end
    end
    return {(ones <= 1), dig};
  endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// One iteration of the multi-cycle arithmetic: a shift-add multiply step or
// a restoring-division step on a shared 2*OPW working register.
module calc_iter_unit #(
  parameter int unsigned OPW = calc_pkg::OPW_DEFAULT
) (
  input  logic              is_div_i,
  input  logic [2*OPW-1:0]  w_i,
  input  logic [OPW-1:0]    m_i,
  output logic [2*OPW-1:0]  w_o
);

  logic [OPW:0]   sum;
  logic [OPW:0]   hi;
  logic [OPW-1:0] rem;
  logic           ge;

  // Multiply: {acc, multiplier} shifts right, adding the multiplicand when
  // the multiplier LSB is set. Divide: {rem, dividend} shifts left, the
  // trial subtraction decides the quotient bit entering at the LSB.
  always_comb begin
    sum = {1'b0, w_i[2*OPW-1:OPW]} + {1'b0, m_i};
    hi  = w_i[2*OPW-1:OPW-1];
    ge  = (hi >= {1'b0, m_i});
    // A successful trial leaves a value below the divisor, so OPW bits suffice.
    rem = hi[OPW-1:0] - m_i;
    if (is_div_i) begin
      if (ge) w_o = {rem, w_i[OPW-2:0], 1'b1};
      else    w_o = {hi[OPW-1:0], w_i[OPW-2:0], 1'b0};
    end else begin
      if (w_i[0]) w_o = {sum, w_i[OPW-1:1]};
      else        w_o = {1'b0, w_i[2*OPW-1:1]};
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: digit-key operand loading, edge-detected buttons and
// an IDLE/CALC/SHOW FSM driving single-cycle add/sub and iterative mul/div.
module calc_sequencer #(
  parameter int unsigned OPW = calc_pkg::OPW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8:0]     num,
  input  logic           loada,
  input  logic           loadb,
  input  logic           go,
  input  logic [3:0]     mode,
  output logic [OPW-1:0] a,
  output logic [OPW-1:0] b,
  output logic [7:0]     op,
  output logic           neg,
  output logic           err,
  output logic           busy,
  output logic           done
);
  import calc_pkg::*;

  localparam int unsigned CW = $clog2(OPW) + 1;
  localparam logic [CW-1:0] LAST = CW'(OPW - 1);

  state_t         state_q;
  logic [OPW-1:0] a_q, b_q, opa_q, opb_q;
  logic [3:0]     mode_q;
  logic [7:0]     op_q;
  logic           neg_q, err_q, busy_q, done_q;
  logic           loada_q, loadb_q, go_q, armed_q;
  logic [2*OPW-1:0] w_q, w_d;
  logic [CW-1:0]  cnt_q;

  logic [4:0]     dec;
  logic           loada_edge, loadb_edge, go_edge;
  logic           finish_d, res_neg_d, res_err_d;
  logic [7:0]     res_d;

  calc_iter_unit #(.OPW(OPW)) u_iter (
    .is_div_i (mode_q == MODE_DIV),
    .w_i      (w_q),
    .m_i      (opb_q),
    .w_o      (w_d)
  );

  // Button edges; armed_q masks the first cycle after reset so a button
  // held through reset does not fire.
  always_comb begin
    dec        = decode_num(num);
    loada_edge = armed_q & loada & ~loada_q;
    loadb_edge = armed_q & loadb & ~loadb_q;
    go_edge    = armed_q & go & ~go_q;
  end

  // Result and completion of the current CALC cycle.
  always_comb begin
    finish_d  = 1'b1;
    res_d     = '0;
    res_neg_d = 1'b0;
    res_err_d = 1'b0;
    case (mode_q)
      MODE_ADD: res_d = 8'(opa_q) + 8'(opb_q);
      MODE_SUB: begin
        if (opa_q >= opb_q) begin
          res_d = 8'(opa_q - opb_q);
        end else begin
          res_d     = 8'(opb_q - opa_q);
          res_neg_d = 1'b1;
        end
      end
      MODE_MUL: begin
        finish_d = (cnt_q == LAST);
        res_d    = 8'(w_d);
      end
      MODE_DIV: begin
        if (opb_q == '0) begin
          res_err_d = 1'b1;
        end else begin
          finish_d = (cnt_q == LAST);
          res_d    = 8'(w_d[OPW-1:0]);
        end
      end
      default: res_err_d = 1'b1;
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      mode_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      loada_q <= 1'b0;
      loadb_q <= 1'b0;
      go_q    <= 1'b0;
      armed_q <= 1'b0;
      w_q     <= '0;
      cnt_q   <= '0;
    end else begin
      loada_q <= loada;
      loadb_q <= loadb;
      go_q    <= go;
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_SHOW: begin
          if (go_edge) begin
            opa_q   <= a_q;
            opb_q   <= b_q;
            mode_q  <= mode;
            w_q     <= {{OPW{1'b0}}, a_q};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end else begin
            if (loada_edge && dec[4]) a_q <= OPW'(dec[3:0]);
            if (loadb_edge && dec[4]) b_q <= OPW'(dec[3:0]);
          end
        end
        S_CALC: begin
          w_q   <= w_d;
          cnt_q <= cnt_q + 1'b1;
          if (finish_d) begin
            op_q    <= res_d;
            neg_q   <= res_neg_d;
            err_q   <= res_err_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_SHOW;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign op   = op_q;
  assign neg  = neg_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: vector table, corner-case sequences and
// randomized operations against an arithmetic reference model.
module tb_calc_sequencer;

  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [8:0]     num;
  logic           loada, loadb, go;
  logic [3:0]     mode;
  logic [OPW-1:0] a, b;
  logic [7:0]     op;
  logic           neg, err, busy, done;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int         a;
    int         b;
    logic [3:0] mode;
    int         op;
    int         neg;
    int         err;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  calc_sequencer #(.OPW(OPW)) dut (
    .clk(clk), .rst(rst), .num(num), .loada(loada), .loadb(loadb), .go(go),
    .mode(mode), .a(a), .b(b), .op(op), .neg(neg), .err(err), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic logic [8:0] onehot(input int d);
    logic [8:0] r;
    r = '0;
    if (d > 0) r[d-1] = 1'b1;
    return r;
  endfunction

  // Reference behaviour from the arithmetic rules, not the datapath.
  function automatic void model(input int x, input int y, input logic [3:0] md,
                                output int o, output int ng, output int er,
                                output int lat);
    o = 0; ng = 0; er = 0; lat = 1;
    if (md == 4'b0001) o = x + y;
    else if (md == 4'b0100) begin
      if (x >= y) o = x - y;
      else begin o = y - x; ng = 1; end
    end else if (md == 4'b0010) begin
      o = x * y; lat = OPW;
    end else if (md == 4'b1000) begin
      if (y == 0) er = 1;
      else begin o = x / y; lat = OPW; end
    end else er = 1;
  endfunction

  task automatic load_ops(input int x, input int y);
    num = onehot(x); loada = 1'b1; tick();
    loada = 1'b0; num = onehot(y); loadb = 1'b1; tick();
    loadb = 1'b0; num = '0; tick();
    check("load a", int'(a), x);
    check("load b", int'(b), y);
  endtask

  // go held for the whole operation (must act once); mode scrambled after
  // the go edge (must have been snapshotted).
  task automatic run_calc(input string name, input logic [3:0] md, input int e_op,
                          input int e_neg, input int e_err, input int lat);
    mode = md; go = 1'b1; tick();
    mode = 4'($urandom);
    for (int n = 1; n <= lat; n++) begin
      check({name, " busy"}, int'(busy), 1);
      check({name, " early done"}, int'(done), 0);
      tick();
    end
    check({name, " done"}, int'(done), 1);
    check({name, " busy end"}, int'(busy), 0);
    check({name, " op"}, int'(op), e_op);
    check({name, " neg"}, int'(neg), e_neg);
    check({name, " err"}, int'(err), e_err);
    tick();
    check({name, " done pulse"}, int'(done), 0);
    check({name, " no retrigger"}, int'(busy), 0);
    check({name, " op held"}, int'(op), e_op);
    go = 1'b0;
  endtask

  initial begin
    int o, ng, er, lat, x, y;
    logic [3:0] md;
    int hold_seq[9];

    vecs[0]  = '{9, 9, 4'b0010, 81, 0, 0, 4};
    vecs[1]  = '{3, 7, 4'b0100,  4, 1, 0, 1};
    vecs[2]  = '{9, 2, 4'b1000,  4, 0, 0, 4};
    vecs[3]  = '{5, 0, 4'b1000,  0, 0, 1, 1};
    vecs[4]  = '{4, 5, 4'b0001,  9, 0, 0, 1};
    vecs[5]  = '{7, 3, 4'b0011,  0, 0, 1, 1};
    vecs[6]  = '{8, 3, 4'b0100,  5, 0, 0, 1};
    vecs[7]  = '{9, 9, 4'b0001, 18, 0, 0, 1};
    vecs[8]  = '{0, 9, 4'b0010,  0, 0, 0, 4};
    vecs[9]  = '{7, 7, 4'b1000,  1, 0, 0, 4};
    vecs[10] = '{1, 8, 4'b1000,  0, 0, 0, 4};
    vecs[11] = '{6, 0, 4'b0000,  0, 0, 1, 1};
    hold_seq = '{1, 3, 4, 5, 1, 5, 3, 4, 5};

    rst = 1'b1; num = '0; loada = 1'b0; loadb = 1'b0; go = 1'b0; mode = 4'b0001;
    tick(); tick();
    check("rst a", int'(a), 0);    check("rst b", int'(b), 0);
    check("rst op", int'(op), 0);  check("rst neg", int'(neg), 0);
    check("rst err", int'(err), 0); check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    rst = 1'b0; tick();

    foreach (vecs[i]) begin
      load_ops(vecs[i].a, vecs[i].b);
      run_calc($sformatf("vec%0d", i), vecs[i].mode, vecs[i].op, vecs[i].neg,
               vecs[i].err, vecs[i].lat);
    end

    // Held loada acts once while num keeps changing; two keys are ignored.
    num = onehot(2); loada = 1'b1; tick();
    check("hold first", int'(a), 2);
    foreach (hold_seq[i]) begin num = onehot(hold_seq[i]); tick(); end
    check("hold a", int'(a), 2);
    loada = 1'b0; tick();
    num = 9'h003; loada = 1'b1; tick();
    loada = 1'b0; num = '0; tick();
    check("multikey a", int'(a), 2);

    // Load edge while busy is ignored.
    load_ops(6, 3);
    mode = 4'b0010; go = 1'b1; tick();
    num = onehot(8); loada = 1'b1; tick();
    check("busy load a", int'(a), 6);
    loada = 1'b0; num = '0;
    for (int n = 2; n <= OPW; n++) tick();
    check("busy load done", int'(done), 1);
    check("busy load op", int'(op), 18);
    check("busy load a end", int'(a), 6);
    go = 1'b0; tick();

    // go has priority over a simultaneous load edge in SHOW.
    num = onehot(1); loada = 1'b1; go = 1'b1; mode = 4'b0001; tick();
    check("prio busy", int'(busy), 1);
    check("prio a", int'(a), 6);
    loada = 1'b0; go = 1'b0; num = '0; tick();
    check("prio done", int'(done), 1);
    check("prio op", int'(op), 9);
    tick();

    // Reset during the 2nd CALC cycle of a multiply.
    load_ops(3, 5);
    mode = 4'b0010; go = 1'b1; tick(); tick();
    rst = 1'b1; tick();
    check("midrst busy", int'(busy), 0); check("midrst done", int'(done), 0);
    check("midrst a", int'(a), 0);       check("midrst b", int'(b), 0);
    check("midrst op", int'(op), 0);     check("midrst neg", int'(neg), 0);
    check("midrst err", int'(err), 0);
    rst = 1'b0; go = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      check("midrst no done", int'(done), 0);
    end

    // Buttons held through reset do not fire afterwards.
    rst = 1'b1; go = 1'b1; loada = 1'b1; num = onehot(7); tick(); tick();
    rst = 1'b0; tick();
    check("heldrst busy1", int'(busy), 0);
    check("heldrst a1", int'(a), 0);
    tick();
    check("heldrst busy2", int'(busy), 0);
    check("heldrst a2", int'(a), 0);
    go = 1'b0; loada = 1'b0; num = '0; tick();

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 9));
      y = int'($urandom_range(0, 9));
      case ($urandom_range(0, 4))
        0: md = 4'b0001;
        1: md = 4'b0010;
        2: md = 4'b0100;
        3: md = 4'b1000;
        default: md = 4'($urandom);
      endcase
      model(x, y, md, o, ng, er, lat);
      load_ops(x, y);
      run_calc($sformatf("rnd%0d", i), md, o, ng, er, lat);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
